// File: rtl/part_2_clk_freeze_sched_if.sv
// Fringe put/get channel between the clock-freeze scheduler (master) and the fringe engine (slave).
interface part_2_clk_freeze_sched_if #(
    parameter int DW = 9
);
    logic          put_req;
    logic [2:0]    put_evt;
    logic          put_ack;
    logic          get_req;
    logic [2:0]    get_evt;
    logic          get_valid;
    logic [DW-1:0] get_data;

    modport master (
        output put_req, put_evt, get_req, get_evt,
        input  put_ack, get_valid, get_data
    );

    modport slave (
        input  put_req, put_evt, get_req, get_evt,
        output put_ack, get_valid, get_data
    );
endinterface

// File: rtl/part_2_clk_freeze_sched.sv
// Freezes mission-clock domains on each edge and round-robin schedules one put/get exchange per edge.
// Optional watchdog and ERROR state enabled by defining CS_SCHED_WD_EN.
module part_2_clk_freeze_sched #(
    parameter int NDOM    = 4,
    parameter int DW      = 9,
    parameter int PUT_OFS = 4,
    parameter int WD_MAX  = 10000
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NDOM-1:0]           edge_req,
    part_2_clk_freeze_sched_if.master fringe,
    output logic [DW-1:0]             rcv_data,
    output logic [NDOM-1:0]           rcv_valid,
    output logic [NDOM-1:0]           freeze_clk,
    output logic                      busy,
    output logic [NDOM-1:0]           overrun,
    output logic                      wd_err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PUT     = 3'd1,
        GET     = 3'd2,
        RELEASE = 3'd3,
        ERROR   = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      grant_q, grant_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [NDOM-1:0] pending_q, pending_d;
    logic [NDOM-1:0] overrun_q, overrun_d;
    logic [DW-1:0]   rcv_data_q, rcv_data_d;
    logic [1:0]      rr_idx;
    logic            rr_found;

    if (NDOM < 1 || NDOM > 4 || WD_MAX < 1) begin : g_param_check
        $error("part_2_clk_freeze_sched: NDOM must be 1..4 and WD_MAX at least 1");
    end

`ifdef CS_SCHED_WD_EN
    localparam int            WD_W    = (WD_MAX > 1) ? $clog2(WD_MAX) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_MAX - 1);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
`endif

    // First pending domain found scanning upward from the round-robin pointer, with wrap.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int k = 0; k < NDOM; k++) begin
            if (!rr_found && pending_q[(int'(ptr_q) + k) % NDOM]) begin
                rr_found = 1'b1;
                rr_idx   = 2'((int'(ptr_q) + k) % NDOM);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        pending_d  = pending_q;
        overrun_d  = overrun_q;
        rcv_data_d = rcv_data_q;
`ifdef CS_SCHED_WD_EN
        wd_cnt_d   = '0;
`endif

        case (state_q)
            IDLE: begin
                if (rr_found) begin
                    grant_d = rr_idx;
                    state_d = PUT;
                end
            end
            PUT: begin
                if (fringe.put_ack) begin
                    state_d = GET;
                end
            end
            GET: begin
                if (fringe.get_valid) begin
                    rcv_data_d = fringe.get_data;
                    state_d    = RELEASE;
                end
            end
            RELEASE: begin
                state_d = IDLE;
                ptr_d   = (int'(grant_q) == NDOM - 1) ? 2'd0 : grant_q + 2'd1;
                for (int i = 0; i < NDOM; i++) begin
                    if (grant_q == 2'(i)) begin
                        pending_d[i] = 1'b0;
                    end
                end
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef CS_SCHED_WD_EN
        // The count restarts on every phase change, so each of PUT and GET gets the full budget.
        if ((state_q == PUT || state_q == GET) && state_d == state_q) begin
            if (wd_cnt_q == WD_LAST) begin
                state_d = ERROR;
            end else begin
                wd_cnt_d = wd_cnt_q + 1'b1;
            end
        end
`endif

        // An edge for the domain being released starts a fresh request rather than an overrun.
        for (int i = 0; i < NDOM; i++) begin
            if (edge_req[i]) begin
                if (pending_q[i] && !(state_q == RELEASE && grant_q == 2'(i))) begin
                    overrun_d[i] = 1'b1;
                end else begin
                    pending_d[i] = 1'b1;
                end
            end
        end

        if (state_d == ERROR) begin
            pending_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            ptr_q      <= '0;
            pending_q  <= '0;
            overrun_q  <= '0;
            rcv_data_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            pending_q  <= pending_d;
            overrun_q  <= overrun_d;
            rcv_data_q <= rcv_data_d;
        end
    end

`ifdef CS_SCHED_WD_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end

    assign wd_err = (state_q == ERROR);
`else
    assign wd_err = 1'b0;
`endif

    always_comb begin
        rcv_valid = '0;
        for (int i = 0; i < NDOM; i++) begin
            if (state_q == RELEASE && grant_q == 2'(i)) begin
                rcv_valid[i] = 1'b1;
            end
        end
    end

    assign fringe.put_req = (state_q == PUT);
    assign fringe.put_evt = (state_q == PUT) ? 3'(PUT_OFS) + {1'b0, grant_q} : 3'd0;
    assign fringe.get_req = (state_q == GET);
    assign fringe.get_evt = (state_q == GET) ? {1'b0, grant_q} : 3'd0;

    assign freeze_clk = pending_q;
    assign busy       = (state_q != IDLE);
    assign overrun    = overrun_q;
    assign rcv_data   = rcv_data_q;

endmodule

// File: tb/tb_part_2_clk_freeze_sched.sv
// Self-checking bench for part_2_clk_freeze_sched: vector table plus scoreboard of expected exchanges.
module tb_part_2_clk_freeze_sched;

    localparam int NDOM    = 4;
    localparam int DW      = 9;
    localparam int PUT_OFS = 4;
    localparam int WD_MAX  = 16;

    logic            clk_i    = 1'b0;
    logic            rst_ni   = 1'b0;
    logic [NDOM-1:0] edge_req = '0;
    logic [DW-1:0]   rcv_data;
    logic [NDOM-1:0] rcv_valid;
    logic [NDOM-1:0] freeze_clk;
    logic            busy;
    logic [NDOM-1:0] overrun;
    logic            wd_err;

    part_2_clk_freeze_sched_if #(.DW(DW)) fringe ();

    part_2_clk_freeze_sched #(
        .NDOM(NDOM), .DW(DW), .PUT_OFS(PUT_OFS), .WD_MAX(WD_MAX)
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .edge_req(edge_req),
        .fringe(fringe.master),
        .rcv_data(rcv_data),
        .rcv_valid(rcv_valid),
        .freeze_clk(freeze_clk),
        .busy(busy),
        .overrun(overrun),
        .wd_err(wd_err)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0]      edges;
        int              ack_gap;
        logic [8:0]      data_base;
        int              n;
        logic [3:0][1:0] order;
    } vec_t;

    typedef struct packed {
        logic [1:0] dom;
        logic [8:0] data;
    } exp_t;

    vec_t       vecs[7];
    exp_t       sb[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_rel    = 0;
    int         ack_gap  = 1;
    logic [8:0] data_base = '0;
    bit         resp_en  = 1'b1;
    bit         get_en   = 1'b1;
    bit         sb_en    = 1'b1;
    logic       prev_put = 1'b0;
    logic       prev_get = 1'b0;
    logic [3:0] exp_frz;

    function automatic vec_t mk(input logic [3:0] e, input int gap, input logic [8:0] base,
                                input int n, input logic [1:0] o0, input logic [1:0] o1,
                                input logic [1:0] o2, input logic [1:0] o3);
        vec_t v;
        v.edges     = e;
        v.ack_gap   = gap;
        v.data_base = base;
        v.n         = n;
        v.order     = {o3, o2, o1, o0};
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reportFail(input string name);
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s: event did not occur within its bound at %0t", name, $time);
    endtask

    // Fringe engine model: acks a put after ack_gap cycles, then answers the get one cycle later.
    initial begin
        fringe.put_ack   = 1'b0;
        fringe.get_valid = 1'b0;
        fringe.get_data  = '0;
        forever begin
            @(negedge clk_i);
            if (resp_en && rst_ni && fringe.put_req) begin
                repeat (ack_gap) @(posedge clk_i);
                #1 fringe.put_ack = 1'b1;
                @(posedge clk_i);
                #1 fringe.put_ack = 1'b0;
                if (get_en) begin
                    @(negedge clk_i);
                    for (int c = 0; c < 20 && !fringe.get_req; c++) @(negedge clk_i);
                    if (fringe.get_req) begin
                        @(posedge clk_i);
                        #1 fringe.get_valid = 1'b1;
                        fringe.get_data = data_base + 9'(fringe.get_evt);
                        @(posedge clk_i);
                        #1 fringe.get_valid = 1'b0;
                    end
                end
            end
        end
    end

    // Scoreboard monitor: the exchange at the queue head owns the next put, get and release.
    always @(negedge clk_i) begin
        if (rcv_valid != '0) n_rel++;
        if (sb_en && rst_ni) begin
            if (fringe.put_req && !prev_put) begin
                if (sb.size() == 0) reportFail("put_unexpected");
                else checkOutput("put_evt", fringe.put_evt, PUT_OFS + sb[0].dom);
            end
            if (fringe.get_req && !prev_get) begin
                if (sb.size() == 0) reportFail("get_unexpected");
                else checkOutput("get_evt", fringe.get_evt, sb[0].dom);
            end
            if (rcv_valid != '0) begin
                if (sb.size() == 0) begin
                    reportFail("release_unexpected");
                end else begin
                    exp_frz = '0;
                    foreach (sb[k]) exp_frz = exp_frz | (4'b0001 << sb[k].dom);
                    checkOutput("rcv_valid", rcv_valid, 4'b0001 << sb[0].dom);
                    checkOutput("rcv_data", rcv_data, sb[0].data);
                    checkOutput("freeze_at_release", freeze_clk, exp_frz);
                    void'(sb.pop_front());
                end
            end
        end
        prev_put = fringe.put_req;
        prev_get = fringe.get_req;
    end

    task automatic waitIdle(input int limit, input string name);
        bit done = 1'b0;
        for (int c = 0; c < limit && !done; c++) begin
            @(negedge clk_i);
            if (sb.size() == 0 && !busy && freeze_clk == '0) done = 1'b1;
        end
        if (!done) reportFail(name);
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        ack_gap   = v.ack_gap;
        data_base = v.data_base;
        for (int k = 0; k < v.n; k++) begin
            sb.push_back('{dom: v.order[k], data: v.data_base + 9'(v.order[k])});
        end
        @(posedge clk_i);
        #1 edge_req = v.edges;
        @(posedge clk_i);
        #1 edge_req = '0;
        @(negedge clk_i);
        checkOutput($sformatf("v%0d_freeze_n1", idx), freeze_clk, v.edges);
        checkOutput($sformatf("v%0d_put_req_n1", idx), fringe.put_req, 1'b0);
        @(negedge clk_i);
        checkOutput($sformatf("v%0d_put_req_n2", idx), fringe.put_req, 1'b1);
        waitIdle(500, $sformatf("v%0d_timeout", idx));
        checkOutput($sformatf("v%0d_overrun", idx), overrun, 4'b0000);
    endtask

    initial begin
        int  rel0;
        int  seen;
        bit  dropped;
        bit  held;
        int  cnt;
        vecs[0] = mk(4'b0001, 3, 9'h1A5, 1, 2'd0, 2'd0, 2'd0, 2'd0);
        vecs[1] = mk(4'b1000, 1, 9'h0F0, 1, 2'd3, 2'd0, 2'd0, 2'd0);
        vecs[2] = mk(4'b1011, 1, 9'h120, 3, 2'd0, 2'd1, 2'd3, 2'd0);
        vecs[3] = mk(4'b1001, 1, 9'h011, 2, 2'd0, 2'd3, 2'd0, 2'd0);
        vecs[4] = mk(4'b0100, 2, 9'h1FC, 1, 2'd2, 2'd0, 2'd0, 2'd0);
        vecs[5] = mk(4'b1001, 1, 9'h080, 2, 2'd3, 2'd0, 2'd0, 2'd0);
        vecs[6] = mk(4'b1111, 2, 9'h133, 4, 2'd1, 2'd2, 2'd3, 2'd0);

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("reset_outputs",
                    {fringe.put_req, fringe.get_req, busy, wd_err, freeze_clk, rcv_valid, overrun, rcv_data},
                    '0);
        checkOutput("reset_evts", {fringe.put_evt, fringe.get_evt}, '0);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
        checkOutput("idle_after_reset", {busy, freeze_clk}, '0);

        for (int i = 0; i < 7; i++) applyStimulus(vecs[i], i);

        $display("[TB] overrun: second edge on a pending domain");
        ack_gap   = 8;
        data_base = 9'h0AA;
        sb.push_back('{dom: 2'd2, data: 9'h0AC});
        rel0 = n_rel;
        @(posedge clk_i); #1 edge_req = 4'b0100;
        @(posedge clk_i); #1 edge_req = '0;
        repeat (4) @(posedge clk_i);
        #1 edge_req = 4'b0100;
        @(posedge clk_i); #1 edge_req = '0;
        waitIdle(500, "overrun_timeout");
        checkOutput("overrun_sticky", overrun, 4'b0100);
        checkOutput("overrun_one_exchange", n_rel - rel0, 1);

        $display("[TB] re-edge in own release cycle");
        ack_gap   = 1;
        data_base = 9'h040;
        sb.push_back('{dom: 2'd1, data: 9'h041});
        sb.push_back('{dom: 2'd1, data: 9'h041});
        seen    = 0;
        dropped = 1'b0;
        @(posedge clk_i); #1 edge_req = 4'b0010;
        @(posedge clk_i); #1 edge_req = '0;
        for (int c = 0; c < 300 && seen < 2; c++) begin
            @(negedge clk_i);
            edge_req = '0;
            if (rcv_valid[1]) begin
                seen++;
                if (seen == 1) edge_req = 4'b0010;
            end else if (!freeze_clk[1]) begin
                dropped = 1'b1;
            end
        end
        edge_req = '0;
        checkOutput("release_reedge_count", seen, 2);
        checkOutput("release_reedge_freeze_held", dropped, 1'b0);
        waitIdle(200, "reedge_timeout");
        checkOutput("release_reedge_no_overrun", overrun, 4'b0100);

        $display("[TB] asynchronous reset during GET");
        sb_en  = 1'b0;
        get_en = 1'b0;
        @(posedge clk_i); #1 edge_req = 4'b0110;
        @(posedge clk_i); #1 edge_req = '0;
        cnt = 0;
        while (cnt < 50 && !fringe.get_req) begin
            @(negedge clk_i);
            cnt++;
        end
        if (!fringe.get_req) reportFail("reset_get_req_wait");
        checkOutput("reset_freeze_before", freeze_clk, 4'b0110);
        #2 rst_ni = 1'b0;
        #1;
        checkOutput("async_reset_outputs",
                    {fringe.put_req, fringe.get_req, busy, wd_err, freeze_clk, rcv_valid, overrun, rcv_data},
                    '0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        held = 1'b0;
        repeat (10) begin
            @(negedge clk_i);
            if (fringe.put_req || fringe.get_req || busy || freeze_clk != '0) held = 1'b1;
        end
        checkOutput("post_reset_quiet", held, 1'b0);
        get_en = 1'b1;

        $display("[TB] watchdog behaviour with a silent fringe");
        resp_en = 1'b0;
        @(posedge clk_i); #1 edge_req = 4'b0001;
        @(posedge clk_i); #1 edge_req = '0;
        cnt = 0;
        while (cnt < 10 && !fringe.put_req) begin
            @(negedge clk_i);
            cnt++;
        end
        if (!fringe.put_req) reportFail("wd_put_req_wait");
`ifdef CS_SCHED_WD_EN
        cnt = 0;
        while (cnt < 200 && fringe.put_req) begin
            cnt++;
            @(negedge clk_i);
        end
        checkOutput("wd_put_cycles", cnt, WD_MAX);
        checkOutput("wd_err_set", wd_err, 1'b1);
        checkOutput("wd_freeze_clear", freeze_clk, 4'b0000);
        checkOutput("wd_get_req", fringe.get_req, 1'b0);
        @(posedge clk_i); #1 edge_req = 4'b0010;
        @(posedge clk_i); #1 edge_req = '0;
        repeat (3) @(negedge clk_i);
        checkOutput("wd_error_sticky", {wd_err, fringe.put_req, freeze_clk}, {1'b1, 1'b0, 4'b0000});
`else
        held = 1'b1;
        repeat (1000) begin
            @(negedge clk_i);
            if (!fringe.put_req || wd_err) held = 1'b0;
        end
        checkOutput("nowd_put_req_held", held, 1'b1);
        checkOutput("nowd_wd_err", wd_err, 1'b0);
        checkOutput("nowd_freeze", freeze_clk, 4'b0001);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
